// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bus: the decode-side beat, the EX-side beat, the flush input and the hazard flag.
// The master modport is the surrounding pipeline; the slave modport is the stage register.
interface id_ex_stage_reg_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 7
);
  logic          flush_in;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] ctrl_in;
  logic [DW-1:0] data1_in;
  logic [DW-1:0] data2_in;
  logic [DW-1:0] imm_in;
  logic [AW-1:0] rs_in;
  logic [AW-1:0] rt_in;
  logic [AW-1:0] rd_in;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] ctrl_out;
  logic [DW-1:0] data1_out;
  logic [DW-1:0] data2_out;
  logic [DW-1:0] imm_out;
  logic [AW-1:0] rs_out;
  logic [AW-1:0] rt_out;
  logic [AW-1:0] rd_out;
  logic          hazard_stall_out;

  modport master (
    output flush_in, in_valid, ctrl_in, data1_in, data2_in, imm_in, rs_in, rt_in, rd_in, out_ready,
    input  in_ready, out_valid, ctrl_out, data1_out, data2_out, imm_out, rs_out, rt_out, rd_out,
           hazard_stall_out
  );

  modport slave (
    input  flush_in, in_valid, ctrl_in, data1_in, data2_in, imm_in, rs_in, rt_in, rd_in, out_ready,
    output in_ready, out_valid, ctrl_out, data1_out, data2_out, imm_out, rs_out, rt_out, rd_out,
           hazard_stall_out
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with a 2-entry skid buffer, flush and NOP-masked control outputs.
// Define ID_EX_LOAD_USE_DETECT_EN to add load-use hazard detection (stalls decode behind a load).
module id_ex_stage_reg #(
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int CW          = 7,
  parameter int MEMREAD_BIT = 4
) (
  input logic              clk,
  input logic              reset_in,
  id_ex_stage_reg_if.slave bus
);

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
  } beat_t;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_SKID = 2'd2} state_t;

  if (MEMREAD_BIT >= CW) begin : g_cfg_chk
    $error("MEMREAD_BIT must index inside the control bundle");
  end

  state_t r_state, w_next;
  beat_t  r_main, r_skid, w_in;
  logic   w_accept, w_drain, w_stall_hz, w_out_valid, w_in_ready;
  logic   w_load_main, w_load_skid, w_skid_to_main;

  assign w_in = '{ctrl: bus.ctrl_in, d1: bus.data1_in, d2: bus.data2_in, imm: bus.imm_in,
                  rs: bus.rs_in, rt: bus.rt_in, rd: bus.rd_in};

  assign w_out_valid = (r_state != S_EMPTY);
  // Ready depends only on local state (and the hazard check), never on out_ready.
  assign w_in_ready  = (r_state != S_SKID) & ~w_stall_hz;
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_drain     = w_out_valid & bus.out_ready;

`ifdef ID_EX_LOAD_USE_DETECT_EN
  logic w_rt_hit;
  assign w_rt_hit   = (r_main.rt == bus.rs_in) | (r_main.rt == bus.rt_in);
  assign w_stall_hz = w_out_valid & r_main.ctrl[MEMREAD_BIT] & bus.in_valid & w_rt_hit &
                      (r_main.rt != '0);
`else
  assign w_stall_hz = 1'b0;
`endif

  always_comb begin
    w_next         = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (bus.flush_in) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) begin
          w_load_main = 1'b1;
          w_next      = S_FULL;
        end
        S_FULL: begin
          if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_drain) begin
            w_next = S_EMPTY;
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_next      = S_SKID;
          end
        end
        S_SKID: if (w_drain) begin
          w_skid_to_main = 1'b1;
          w_next         = S_FULL;
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_main)         r_main <= w_in;
      else if (w_skid_to_main) r_main <= r_skid;
      if (w_load_skid)         r_skid <= w_in;
    end
  end

  assign bus.in_ready         = w_in_ready;
  assign bus.out_valid        = w_out_valid;
  assign bus.ctrl_out         = w_out_valid ? r_main.ctrl : '0;
  assign bus.data1_out        = r_main.d1;
  assign bus.data2_out        = r_main.d2;
  assign bus.imm_out          = r_main.imm;
  assign bus.rs_out           = r_main.rs;
  assign bus.rt_out           = r_main.rt;
  assign bus.rd_out           = r_main.rd;
  assign bus.hazard_stall_out = w_stall_hz;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: vector table, hand-written corner sequences, and a random run
// against a queue-based model of a depth-2 FIFO stage.
module tb_id_ex_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DW(32), .AW(5), .CW(7)) bus ();

  id_ex_stage_reg #(.DW(32), .AW(5), .CW(7), .MEMREAD_BIT(4)) dut (
    .clk(clk), .reset_in(rst), .bus(bus)
  );

  localparam logic [6:0] K_CTRL = 7'h4B;  // no MemRead bit

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] d;
    logic        eov, eir;
    logic [31:0] ed;
  } vec_t;

  typedef struct {
    logic [6:0]  ctrl;
    logic [31:0] d1, d2;
    logic [4:0]  rt, rd;
  } mb_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [6:0] c,
                       input logic [31:0] d1, input logic [4:0] rs, input logic [4:0] rt);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.flush_in  = fl;
    bus.ctrl_in   = c;
    bus.data1_in  = d1;
    bus.data2_in  = ~d1;
    bus.imm_in    = d1 ^ 32'h0000_FFFF;
    bus.rs_in     = rs;
    bus.rt_in     = rt;
    bus.rd_in     = 5'd7;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, '0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[13];
  mb_t  q[$];

  initial begin
    // streaming
    tbl[0]  = '{1, 1, 0, 32'h11, 1, 1, 32'h11};
    tbl[1]  = '{1, 1, 0, 32'h22, 1, 1, 32'h22};
    tbl[2]  = '{1, 1, 0, 32'h33, 1, 1, 32'h33};
    tbl[3]  = '{0, 1, 0, 32'h00, 0, 1, 32'h00};
    // back-pressure: A, B accepted, C refused, then drain A then B
    tbl[4]  = '{1, 0, 0, 32'hA0, 1, 1, 32'hA0};
    tbl[5]  = '{1, 0, 0, 32'hB0, 1, 0, 32'hA0};
    tbl[6]  = '{1, 0, 0, 32'hC0, 1, 0, 32'hA0};
    tbl[7]  = '{0, 1, 0, 32'h00, 1, 1, 32'hB0};
    tbl[8]  = '{0, 1, 0, 32'h00, 0, 1, 32'h00};
    // flush from SKID with an incoming beat
    tbl[9]  = '{1, 0, 0, 32'hD0, 1, 1, 32'hD0};
    tbl[10] = '{1, 0, 0, 32'hE0, 1, 0, 32'hD0};
    tbl[11] = '{1, 0, 1, 32'hF0, 0, 1, 32'h00};
    tbl[12] = '{0, 1, 0, 32'h00, 0, 1, 32'h00};

    drive(0, 0, 0, '0, '0, '0, '0);
    #1;
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_ctrl", 128'(bus.ctrl_out), 128'(0));
    chk("reset_hazard", 128'(bus.hazard_stall_out), 128'(0));
    chk("reset_data", {bus.data1_out, bus.data2_out, bus.imm_out}, 128'(0));
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, K_CTRL, tbl[i].d, 5'd1, 5'd2);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 128'(bus.out_valid), 128'(tbl[i].eov));
      chk($sformatf("vec%0d_in_ready", i), 128'(bus.in_ready), 128'(tbl[i].eir));
      chk($sformatf("vec%0d_ctrl", i), 128'(bus.ctrl_out), 128'(tbl[i].eov ? K_CTRL : 7'h0));
      if (tbl[i].eov) chk($sformatf("vec%0d_data1", i), 128'(bus.data1_out), 128'(tbl[i].ed));
    end

    // reset while in SKID: outputs clear without a clock edge
    @(negedge clk);
    drive(1, 0, 0, K_CTRL, 32'h99, 5'd1, 5'd2);
    @(negedge clk);
    drive(1, 0, 0, K_CTRL, 32'h9A, 5'd1, 5'd2);
    @(negedge clk);
    chk("pre_reset_skid_in_ready", 128'(bus.in_ready), 128'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_valid_ctrl", {bus.out_valid, bus.ctrl_out, bus.hazard_stall_out}, 128'(0));
    chk("async_reset_data", {bus.data1_out, bus.data2_out, bus.imm_out}, 128'(0));
    chk("async_reset_addr", {bus.rs_out, bus.rt_out, bus.rd_out}, 128'(0));
    drive(0, 0, 0, '0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 128'(bus.in_ready), 128'(1));
    chk("post_reset_out_valid", 128'(bus.out_valid), 128'(0));

    // load-use: held load with rt=5, decode reads rs=5
    @(negedge clk);
    drive(1, 0, 0, 7'h10, 32'h55, 5'd0, 5'd5);
    @(negedge clk);
    drive(1, 1, 0, K_CTRL, 32'h66, 5'd5, 5'd1);
    #1;
`ifdef ID_EX_LOAD_USE_DETECT_EN
    chk("lu_hazard", 128'(bus.hazard_stall_out), 128'(1));
    chk("lu_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk);
    #1;
    chk("lu_drained_valid", 128'(bus.out_valid), 128'(0));
    chk("lu_drained_hazard", 128'(bus.hazard_stall_out), 128'(0));
    @(posedge clk);
    #1;
    chk("lu_late_accept_valid", 128'(bus.out_valid), 128'(1));
    chk("lu_late_accept_data", 128'(bus.data1_out), 128'(32'h66));
`else
    chk("lu_hazard", 128'(bus.hazard_stall_out), 128'(0));
    chk("lu_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1;
    chk("lu_accept_valid", 128'(bus.out_valid), 128'(1));
    chk("lu_accept_data", 128'(bus.data1_out), 128'(32'h66));
`endif

    // load with rt=0 never stalls
    do_reset();
    drive(1, 0, 0, 7'h10, 32'h77, 5'd0, 5'd0);
    @(negedge clk);
    drive(1, 0, 0, K_CTRL, 32'h78, 5'd0, 5'd0);
    #1;
    chk("lu_rt0_hazard", 128'(bus.hazard_stall_out), 128'(0));
    chk("lu_rt0_in_ready", 128'(bus.in_ready), 128'(1));

    // randomized run against the FIFO model
    do_reset();
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        iv, ordy, fl, hz, ov, ir;
      logic [6:0]  c, ectrl;
      logic [31:0] d;
      logic [4:0]  rs, rt;
      mb_t         nb;
      @(negedge clk);
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      c    = 7'($urandom);
      d    = $urandom;
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      drive(iv, ordy, fl, c, d, rs, rt);
      #1;
      ov = (q.size() > 0);
      hz = 1'b0;
`ifdef ID_EX_LOAD_USE_DETECT_EN
      if (ov && iv && q[0].ctrl[4] && q[0].rt != 0 && (q[0].rt == rs || q[0].rt == rt)) hz = 1'b1;
`endif
      ir    = (q.size() < 2) && !hz;
      ectrl = ov ? q[0].ctrl : 7'h0;
      chk($sformatf("rnd%0d_ctl", cyc),
          128'({bus.out_valid, bus.in_ready, bus.hazard_stall_out, bus.ctrl_out}),
          128'({ov, ir, hz, ectrl}));
      if (ov)
        chk($sformatf("rnd%0d_data", cyc),
            {bus.data1_out, bus.data2_out, bus.rt_out, bus.rd_out},
            {q[0].d1, q[0].d2, q[0].rt, q[0].rd});
      @(posedge clk);
      if (fl) q.delete();
      else begin
        if (ov && ordy) void'(q.pop_front());
        if (iv && ir) begin
          nb = '{ctrl: c, d1: d, d2: ~d, rt: rt, rd: 5'd7};
          q.push_back(nb);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
